jtpopeye_uart_bus: RTL and testbench

JTPOPEYE_UART_BUS -- requirements
Module: jtpopeye_uart_bus

---
 rtl/jtpopeye_uart_pkg.sv | 50 +++++
 rtl/jtpopeye_uart_bus_if.sv | 15 +
 rtl/jtpopeye_uart_fifo.sv | 54 +++++
 rtl/jtpopeye_uart_bus.sv | 177 +++++++++++++++++
 tb/tb_jtpopeye_uart_bus.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtpopeye_uart_pkg.sv
// Shared register indices, status/control bit positions and TX FSM encoding
// for the jtpopeye UART CPU bridge.
package jtpopeye_uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_RXCNT  = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_RX_ERR   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam int CTRL_IEN_RX  = 0;
  localparam int CTRL_IEN_TXE = 1;
  localparam int CTRL_IEN_ERR = 2;
  localparam int CTRL_CLR     = 7;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LOAD      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic tx_ovf;
    logic rx_err;
    logic rx_ovf;
  } flags_t;

  function automatic logic [BYTE_W-1:0] make_status(input flags_t f, input logic tx_empty,
                                                    input logic tx_full, input logic rx_avail);
    logic [BYTE_W-1:0] s;
    s              = '0;
    s[ST_RX_AVAIL] = rx_avail;
    s[ST_TX_FULL]  = tx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_RX_OVF]   = f.rx_ovf;
    s[ST_RX_ERR]   = f.rx_err;
    s[ST_TX_OVF]   = f.tx_ovf;
    return s;
  endfunction

endpackage

// File: rtl/jtpopeye_uart_bus_if.sv
// CPU-side register bus of the UART bridge: select, strobes, address, data, interrupt.
interface jtpopeye_uart_bus_if;
  import jtpopeye_uart_pkg::*;

  logic              cs;
  logic [1:0]        addr;
  logic              rd_n;
  logic              wr_n;
  logic [BYTE_W-1:0] din;
  logic [BYTE_W-1:0] dout;
  logic              irq_n;

  modport master (output cs, addr, rd_n, wr_n, din, input dout, irq_n);
  modport slave  (input cs, addr, rd_n, wr_n, din, output dout, irq_n);
endinterface

// File: rtl/jtpopeye_uart_fifo.sv
// Synchronous FIFO of 2**AW entries; push into a full FIFO is accepted only when a pop
// happens in the same cen cycle, and a pop of an empty FIFO is ignored.
module jtpopeye_uart_fifo
  import jtpopeye_uart_pkg::*;
#(
  parameter int AW     = 4,
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = cen & pop & ~empty;
  assign do_push = cen & push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset: emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtpopeye_uart_bus.sv
// CPU register bridge between a Z80-style I/O port and jtframe_uart, with RX/TX FIFOs.
// Optional interrupt logic is enabled by defining JTPOPEYE_UART_IRQ_EN.
module jtpopeye_uart_bus
  import jtpopeye_uart_pkg::*;
#(
  parameter int RXAW = 4,
  parameter int TXAW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jtpopeye_uart_bus_if.slave bus,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_error,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_busy
);

  logic              rd_act, wr_act;
  logic              rd_l, wr_l;
  logic              rd_start, rd_end, wr_start;
  logic              rd_pop_arm;

  logic              rx_pop, rx_full, rx_empty;
  logic [RXAW:0]     rx_count;
  logic [BYTE_W-1:0] rx_head;

  logic              tx_push, tx_pop, tx_full, tx_fifo_empty;
  logic [TXAW:0]     tx_count_unused;
  logic [BYTE_W-1:0] tx_head;
  logic [BYTE_W-1:0] tx_last;

  tx_state_t         state, state_nx;
  flags_t            flags;
  logic              ctrl_wr, flag_clr;
  logic              rx_ovf_set, rx_err_set, tx_ovf_set;
  logic              tx_empty_st;
  logic [2:0]        ctrl;

  // Strobe edge detection: each access acts once on its first and last sampled cycle.
  assign rd_act   = bus.cs & ~bus.rd_n;
  assign wr_act   = bus.cs & ~bus.wr_n;
  assign rd_start = cen & rd_act & ~rd_l;
  assign rd_end   = cen & ~rd_act & rd_l;
  assign wr_start = cen & wr_act & ~wr_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_l       <= 1'b0;
      wr_l       <= 1'b0;
      rd_pop_arm <= 1'b0;
    end else if (cen) begin
      rd_l <= rd_act;
      wr_l <= wr_act;
      if (rd_start)    rd_pop_arm <= (bus.addr == REG_DATA) & ~rx_empty;
      else if (rd_end) rd_pop_arm <= 1'b0;
    end
  end

  assign rx_pop   = rd_end & rd_pop_arm;
  assign tx_push  = wr_start & (bus.addr == REG_DATA);
  assign ctrl_wr  = wr_start & (bus.addr == REG_CTRL);
  assign flag_clr = ctrl_wr & bus.din[CTRL_CLR];

  jtpopeye_uart_fifo #(.AW(RXAW), .DATA_W(BYTE_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .push  (rx_done),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  jtpopeye_uart_fifo #(.AW(TXAW), .DATA_W(BYTE_W)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.din),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_fifo_empty),
    .count (tx_count_unused)
  );

  // A drop only happens when the full FIFO is not also being drained this cycle.
  assign rx_ovf_set = cen & rx_done & rx_full & ~rx_pop;
  assign rx_err_set = cen & rx_error;
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (cen) begin
      flags.rx_ovf <= rx_ovf_set | (flags.rx_ovf & ~flag_clr);
      flags.rx_err <= rx_err_set | (flags.rx_err & ~flag_clr);
      flags.tx_ovf <= tx_ovf_set | (flags.tx_ovf & ~flag_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      tx_last <= '0;
    end else if (cen) begin
      state <= state_nx;
      if (state == TX_LOAD) tx_last <= tx_head;
    end
  end

  always_comb begin
    state_nx = state;
    tx_wr    = 1'b0;
    tx_data  = tx_last;
    tx_pop   = 1'b0;
    unique case (state)
      TX_IDLE:      if (!tx_fifo_empty && !tx_busy) state_nx = TX_LOAD;
      TX_LOAD: begin
        tx_wr    = 1'b1;
        tx_data  = tx_head;
        tx_pop   = cen;
        state_nx = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (tx_busy)  state_nx = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) state_nx = TX_IDLE;
      default:      state_nx = TX_IDLE;
    endcase
  end

  assign tx_empty_st = tx_fifo_empty & (state == TX_IDLE);

`ifdef JTPOPEYE_UART_IRQ_EN
  logic irq_r;
  logic unused_din;

  assign unused_din = ^bus.din[6:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl  <= '0;
      irq_r <= 1'b1;
    end else if (cen) begin
      if (ctrl_wr) ctrl <= bus.din[2:0];
      irq_r <= ~((~rx_empty & ctrl[CTRL_IEN_RX]) |
                 (tx_empty_st & ctrl[CTRL_IEN_TXE]) |
                 ((flags.rx_ovf | flags.rx_err | flags.tx_ovf) & ctrl[CTRL_IEN_ERR]));
    end
  end

  assign bus.irq_n = irq_r;
`else
  logic unused_din;

  assign unused_din = ^bus.din[6:0];
  assign ctrl       = '0;
  assign bus.irq_n  = 1'b1;
`endif

  always_comb begin
    bus.dout = '0;
    unique case (bus.addr)
      REG_STATUS: bus.dout = make_status(flags, tx_empty_st, tx_full, ~rx_empty);
      REG_RXCNT:  bus.dout = BYTE_W'(rx_count);
      REG_DATA:   bus.dout = rx_head;
      REG_CTRL:   bus.dout = {5'b0, ctrl};
      default:    bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_jtpopeye_uart_bus.sv
// Randomised bench for jtpopeye_uart_bus (RXAW=TXAW=2) with a queue-based reference model.
module tb_jtpopeye_uart_bus;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] got_tx[$];
  bit m_rx_ovf = 0, m_rx_err = 0, m_tx_ovf = 0;
  int busy_cnt = 0;
  bit busy_hold = 0;

  jtpopeye_uart_bus_if bus();

  jtpopeye_uart_bus #(.RXAW(2), .TXAW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_error (rx_error),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: each accepted byte keeps busy high for 10 cen cycles.
  always @(negedge clk) begin
    if (cen && rst_n) begin
      if (tx_wr) begin
        got_tx.push_back(tx_data);
        busy_cnt <= 10;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end
  assign tx_busy = (busy_cnt != 0) || busy_hold;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic void m_rx_push(input logic [7:0] d, input bit err);
    if (err) m_rx_err = 1;
    if (rx_q.size() < 4) rx_q.push_back(d);
    else m_rx_ovf = 1;
  endfunction

  function automatic void m_tx_push(input logic [7:0] d);
    if (tx_q.size() < 4) tx_q.push_back(d);
    else m_tx_ovf = 1;
  endfunction

  function automatic logic [7:0] exp_status(input bit tx_empty, input bit tx_full);
    return {2'b00, m_tx_ovf, m_rx_err, m_rx_ovf, tx_empty, tx_full, rx_q.size() != 0};
  endfunction

  task automatic tick();
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit err);
    rx_data = d; rx_done = 1'b1; rx_error = err;
    tick();
    rx_done = 1'b0; rx_error = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input int hold, output logic [7:0] d, output bit stable);
    bus.addr = a; bus.cs = 1'b1; bus.rd_n = 1'b0;
    #1;
    d = bus.dout;
    stable = 1;
    repeat (hold) begin
      tick();
      if (bus.dout !== d) stable = 0;
    end
    bus.rd_n = 1'b1;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold);
    bus.addr = a; bus.din = d; bus.cs = 1'b1; bus.wr_n = 1'b0;
    repeat (hold) tick();
    bus.wr_n = 1'b1;
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic clear_flags();
    bus_write(2'd3, 8'h80, 1);
    m_rx_ovf = 0; m_rx_err = 0; m_tx_ovf = 0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    bus.cs = 1'b0; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.addr = 2'd0; bus.din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr got %b want 0", tx_wr); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (bus.irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n got %b want 1", bus.irq_n); end
    rst_n = 1'b1;
    tick();
    peek(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_status got %h want 04", d); end
    peek(2'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rxcnt got %h want 00", d); end
    peek(2'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_head got %h want 00", d); end
    peek(2'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", d); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] vals [5];
    logic [7:0] d, e;
    bit st;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (vals[i]) begin
      rx_byte(vals[i], 0);
      m_rx_push(vals[i], 0);
    end
    peek(2'd1, d);
    checks++; if (d !== 8'(rx_q.size())) begin errors++; $display("FAIL ovf_count got %h want %h", d, rx_q.size()); end
    peek(2'd0, d);
    checks++; if (d !== exp_status(1, 0)) begin errors++; $display("FAIL ovf_status got %h want %h", d, exp_status(1, 0)); end
    for (int i = 0; i < 4; i++) begin
      e = rx_q.pop_front();
      bus_read(2'd2, 1, d, st);
      checks++; if (d !== e) begin errors++; $display("FAIL ovf_read%0d got %h want %h", i, d, e); end
    end
    peek(2'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL empty_head got %h want 00", d); end
    bus_read(2'd2, 1, d, st);
    peek(2'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL empty_read_count got %h want 00", d); end
    rx_byte(8'h66, 0);
    m_rx_push(8'h66, 0);
    e = rx_q.pop_front();
    bus_read(2'd2, 1, d, st);
    checks++; if (d !== e) begin errors++; $display("FAIL after_empty_read got %h want %h", d, e); end
    clear_flags();
    peek(2'd0, d);
    checks++; if (d !== exp_status(1, 0)) begin errors++; $display("FAIL flag_clear got %h want %h", d, exp_status(1, 0)); end
  endtask

  task automatic test_long_read();
    logic [7:0] d, e;
    bit st;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      rx_byte(d, 0);
      m_rx_push(d, 0);
    end
    e = rx_q.pop_front();
    bus_read(2'd2, 5, d, st);
    checks++; if (d !== e || !st) begin errors++; $display("FAIL long_read got %h stable %0d want %h stable 1", d, st, e); end
    peek(2'd1, d);
    checks++; if (d !== 8'(rx_q.size())) begin errors++; $display("FAIL long_read_count got %h want %h", d, rx_q.size()); end
    while (rx_q.size() != 0) begin
      e = rx_q.pop_front();
      bus_read(2'd2, 1, d, st);
      checks++; if (d !== e) begin errors++; $display("FAIL long_drain got %h want %h", d, e); end
    end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] d, e, nb;
    bit st;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      rx_byte(d, 0);
      m_rx_push(d, 0);
    end
    clear_flags();
    nb = 8'($urandom);
    bus.addr = 2'd2; bus.cs = 1'b1; bus.rd_n = 1'b0;
    #1;
    d = bus.dout;
    tick();
    bus.rd_n = 1'b1;
    rx_data = nb; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; bus.cs = 1'b0;
    e = rx_q.pop_front();
    rx_q.push_back(nb);
    checks++; if (d !== e) begin errors++; $display("FAIL simul_head got %h want %h", d, e); end
    peek(2'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL simul_count got %h want 04", d); end
    peek(2'd0, d);
    checks++; if (d !== exp_status(1, 0)) begin errors++; $display("FAIL simul_status got %h want %h", d, exp_status(1, 0)); end
    while (rx_q.size() != 0) begin
      e = rx_q.pop_front();
      bus_read(2'd2, 1, d, st);
      checks++; if (d !== e) begin errors++; $display("FAIL simul_drain got %h want %h", d, e); end
    end
  endtask

  task automatic test_random_rx();
    logic [7:0] d, e;
    bit st, er;
    int op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      if (op < 2) begin
        d = 8'($urandom);
        er = ($urandom_range(0, 7) == 0);
        rx_byte(d, er);
        m_rx_push(d, er);
      end else if (op == 2) begin
        e = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        bus_read(2'd2, $urandom_range(1, 3), d, st);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        checks++; if (d !== e) begin errors++; $display("FAIL rand_read%0d got %h want %h", i, d, e); end
      end else begin
        peek(2'd1, d);
        checks++; if (d !== 8'(rx_q.size())) begin errors++; $display("FAIL rand_count%0d got %h want %h", i, d, rx_q.size()); end
        peek(2'd0, d);
        checks++; if (d !== exp_status(1, 0)) begin errors++; $display("FAIL rand_status%0d got %h want %h", i, d, exp_status(1, 0)); end
      end
    end
    clear_flags();
    while (rx_q.size() != 0) begin
      e = rx_q.pop_front();
      bus_read(2'd2, 1, d, st);
      checks++; if (d !== e) begin errors++; $display("FAIL rand_drain got %h want %h", d, e); end
    end
  endtask

  task automatic test_tx_basic();
    logic [7:0] d;
    int base;
    bit seen;
    base = got_tx.size();
    seen = 0;
    bus_write(2'd2, 8'h41, 3);
    bus_write(2'd2, 8'h42, 1);
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      peek(2'd0, d);
      if (d[2]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL tx_empty_timeout got 0 want 1");
    end else if (got_tx.size() - base != 2 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL tx_empty_early got pulses %0d busy %b want 2 busy 0", got_tx.size() - base, tx_busy);
    end
    repeat (5) tick();
    checks++; if (got_tx.size() - base != 2) begin errors++; $display("FAIL tx_pulses got %0d want 2", got_tx.size() - base); end
    if (got_tx.size() - base >= 2) begin
      checks++; if (got_tx[base] !== 8'h41 || got_tx[base+1] !== 8'h42) begin
        errors++; $display("FAIL tx_bytes got %h %h want 41 42", got_tx[base], got_tx[base+1]);
      end
    end
    checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL tx_data_hold got %h want 42", tx_data); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d, e;
    int base;
    bit seen;
    base = got_tx.size();
    seen = 0;
    busy_hold = 1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      bus_write(2'd2, d, 1);
      m_tx_push(d);
    end
    peek(2'd0, d);
    checks++; if (d !== exp_status(0, 1)) begin errors++; $display("FAIL tx_ovf_status got %h want %h", d, exp_status(0, 1)); end
    busy_hold = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      peek(2'd0, d);
      if (d[2]) seen = 1;
    end
    checks++; if (!seen || got_tx.size() - base != 4) begin
      errors++; $display("FAIL tx_ovf_drain got pulses %0d done %0d want 4 done 1", got_tx.size() - base, seen);
    end
    for (int i = 0; i < 4 && base + i < got_tx.size(); i++) begin
      e = tx_q.pop_front();
      checks++; if (got_tx[base+i] !== e) begin errors++; $display("FAIL tx_ovf_byte%0d got %h want %h", i, got_tx[base+i], e); end
    end
    tx_q.delete();
    clear_flags();
  endtask

  task automatic test_irq();
    logic [7:0] d, e;
    bit st;
    bus_write(2'd3, 8'h01, 1);
    peek(2'd3, d);
`ifdef JTPOPEYE_UART_IRQ_EN
    e = 8'h01;
`else
    e = 8'h00;
`endif
    checks++; if (d !== e) begin errors++; $display("FAIL irq_ctrl got %h want %h", d, e); end
    checks++; if (bus.irq_n !== 1'b1) begin errors++; $display("FAIL irq_idle got %b want 1", bus.irq_n); end
    rx_byte(8'h77, 0);
    m_rx_push(8'h77, 0);
    tick();
`ifdef JTPOPEYE_UART_IRQ_EN
    st = 0;
`else
    st = 1;
`endif
    checks++; if (bus.irq_n !== st) begin errors++; $display("FAIL irq_rx got %b want %b", bus.irq_n, st); end
    e = rx_q.pop_front();
    bus_read(2'd2, 1, d, st);
    checks++; if (d !== e) begin errors++; $display("FAIL irq_read got %h want %h", d, e); end
    tick();
    checks++; if (bus.irq_n !== 1'b1) begin errors++; $display("FAIL irq_release got %b want 1", bus.irq_n); end
    bus_write(2'd3, 8'h00, 1);
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    int base;
    rx_byte(8'h5a, 0);
    m_rx_push(8'h5a, 0);
    base = got_tx.size();
    for (int i = 0; i < 4; i++) bus_write(2'd2, 8'($urandom), 1);
    for (int i = 0; i < 30 && got_tx.size() == base; i++) tick();
    checks++; if (got_tx.size() != base + 1) begin errors++; $display("FAIL midtx_first got %0d want 1", got_tx.size() - base); end
    busy_hold = 1;
    repeat (2) tick();
    peek(2'd0, d);
    checks++; if (d[2] !== 1'b0 || d[0] !== 1'b1) begin errors++; $display("FAIL midtx_pre_status got %h want tx_empty 0 rx_avail 1", d); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_wr !== 1'b0 || tx_data !== 8'h00 || bus.irq_n !== 1'b1) begin
      errors++; $display("FAIL midtx_outputs got wr %b data %h irq %b want 0 00 1", tx_wr, tx_data, bus.irq_n);
    end
    peek(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL midtx_status got %h want 04", d); end
    peek(2'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midtx_rxcnt got %h want 00", d); end
    rx_q.delete();
    m_rx_ovf = 0; m_rx_err = 0; m_tx_ovf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = got_tx.size();
    repeat (20) tick();
    busy_hold = 0;
    repeat (30) tick();
    checks++; if (got_tx.size() != base) begin errors++; $display("FAIL midtx_no_pulse got %0d want 0", got_tx.size() - base); end
    peek(2'd0, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL midtx_final_status got %h want 04", d); end
  endtask

  initial begin
    test_reset();
    test_rx_overflow();
    test_long_read();
    test_simul_push_pop();
    test_random_rx();
    test_tx_basic();
    test_tx_overflow();
    test_irq();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
